// File: rtl/mult_result_serializer.sv
// Serializes one 2*WORD_LENGTH-bit product per handshake into NUM_BEATS
// BEAT_WIDTH-bit beats, least-significant beat first, with zero-bubble reload.
module mult_result_serializer #(
  parameter int WORD_LENGTH = 32,
  parameter int BEAT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prod_valid,
  input  logic [2*WORD_LENGTH-1:0] prod_data,
  output logic                     prod_ready,
  output logic                     out_valid,
  output logic [BEAT_WIDTH-1:0]    out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int PROD_WIDTH = 2 * WORD_LENGTH;
  localparam int NUM_BEATS  = PROD_WIDTH / BEAT_WIDTH;
  localparam int CNT_WIDTH  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_BEATS - 1);

  if (((PROD_WIDTH % BEAT_WIDTH) != 0) || (NUM_BEATS < 2)) begin : g_bad_params
    $error("mult_result_serializer: BEAT_WIDTH must divide 2*WORD_LENGTH into at least 2 beats");
  end

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                 state_q, state_d;
  logic [PROD_WIDTH-1:0]  shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   accept;
  logic                   xfer;

  assign out_valid  = (state_q == SEND);
  assign out_last   = (state_q == SEND) && (cnt_q == LAST_CNT);
  assign out_data   = (state_q == SEND) ? shreg_q[BEAT_WIDTH-1:0] : '0;
  assign busy       = (state_q == SEND);
  // Ready is combinational on out_ready so a new product can load on the
  // final-beat cycle without an idle gap between bursts.
  assign prod_ready = !reset && ((state_q == IDLE) || (out_last && out_ready));
  assign accept     = prod_valid && prod_ready;
  assign xfer       = out_valid && out_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = prod_data;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (!out_last) begin
            shreg_d = shreg_q >> BEAT_WIDTH;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
          end else if (accept) begin
            shreg_d = prod_data;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/mult_result_serializer.md
Name: mult_result_serializer

Overview:
- Output-side partner to the multiplier operand/result registers: accepts one full-width product per valid/ready handshake.
- Drains the product onto a narrower BEAT_WIDTH bus as a burst of beats, least-significant beat first.
- Sits between the multiplier's product register and the downstream result bus. Supports backpressure and zero-bubble back-to-back products.

Parameters:
- WORD_LENGTH, 32, operand width; the product is 2*WORD_LENGTH bits.
- BEAT_WIDTH, 16, output beat width; must divide 2*WORD_LENGTH exactly.
- NUM_BEATS is derived, not overridable: NUM_BEATS = 2*WORD_LENGTH/BEAT_WIDTH, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- prod_valid  input  1  a product is offered on prod_data.
- prod_data  input  2*WORD_LENGTH  product value; sampled only on the accept cycle.
- prod_ready  output  1  block can accept a product this cycle.
- out_valid  output  1  out_data holds a valid beat.
- out_data  output  BEAT_WIDTH  current beat.
- out_last  output  1  current beat is the final beat of the product.
- out_ready  input  1  downstream accepts the beat.
- busy  output  1  a product is held or in transfer.

Behaviour:
- One clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state IDLE, beat counter 0, shift register 0.
  - out_valid=0, out_last=0, out_data=0, busy=0.
  - prod_ready=1 from the first cycle after reset, as long as reset is low.
- While reset is high: prod_ready=0; any product or beat on the bus is discarded.
- States:
  - IDLE: out_valid=0, prod_ready=1. An accept (prod_valid & prod_ready) loads prod_data into the shift register, clears the counter and moves to SEND.
  - SEND: out_valid=1; out_data = shift register bits [BEAT_WIDTH-1:0]; out_last = (counter == NUM_BEATS-1).
- Beat handshake in SEND: a beat transfers when out_valid & out_ready.
  - On transfer with out_last=0: shift register shifts right by BEAT_WIDTH, zero-filled; counter increments.
  - On transfer with out_last=1, no product accepted the same cycle: go to IDLE.
  - On transfer with out_last=1 and prod_valid=1: the new product is loaded, the counter resets to 0, the state stays SEND. This gives a zero-bubble back-to-back burst.
- Backpressure: while out_ready=0 in SEND, out_data, out_last, out_valid and the counter hold stable. Once raised, out_valid never drops before its beat transfers.
- prod_ready is combinational: (state==IDLE) | (state==SEND & out_last & out_ready).
  - This is the only combinational input-to-output path.
  - prod_valid while prod_ready=0 is ignored; the source holds prod_valid and prod_data stable until accepted.
- busy = (state==SEND). It is registered and deasserts the cycle after a final beat transfers with no new accept.
- Latency: the first beat is visible on out_data the cycle after accept.
  - Minimum burst is NUM_BEATS cycles.
  - Sustained throughput is one product per NUM_BEATS cycles with out_ready held high.
- Counter is clog2(NUM_BEATS) bits wide and never exceeds NUM_BEATS-1. There is no wrap-around path other than reload.
- Reset mid-burst: the burst is abandoned and remaining beats are never emitted. The cycle after reset deasserts, the block is in IDLE with all outputs at reset values.
- Elaboration: a non-divisible BEAT_WIDTH, or NUM_BEATS < 2, is an elaboration error (generate-time check).

Test Plan:
- Reset, then idle, with W=32, B=16 -> out_valid=0, out_last=0, busy=0 and prod_ready=1 on the first post-reset cycle; out_data=0.
- Accept 0x1122334455667788, out_ready held 1 -> beats 0x7788, 0x5566, 0x3344, 0x1122 on consecutive cycles; out_last only on 0x1122; busy low the next cycle.
- Same product, out_ready pulsed 1-0-0-1-0-1-1 -> each beat held stable while out_ready=0; 4 transfers in order; no beat duplicated or skipped.
- prod_valid held 1 with 0xAAAA5555DEADBEEF then 0x0000000100000002 -> first product's beats, then 0x0002, 0x0000, 0x0001, 0x0000 with no idle cycle between bursts; prod_ready high only on the last-beat cycles and in IDLE.
- reset asserted after the 2nd beat (0x5566) transfers -> next cycle out_valid=0, busy=0; 0x3344 and 0x1122 never appear; a fresh product 0x0000000000000001 then yields 0x0001, 0x0000, 0x0000, 0x0000.
- prod_valid asserted mid-burst with out_last=0 -> ignored until the final-beat accept cycle; prod_data changes before then have no effect on the captured value.
